// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Total clk16x cycles for one frame: start + data + optional parity + 1 or 2 stops.
    function automatic int frame_cycles(input int data_bits, input int par_en,
                                        input int stop2, input int oversample);
        return (2 + data_bits + par_en + stop2) * oversample;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; read data is the head word.
module sync_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk16x,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_BITS-1:0]          din,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count_nxt;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk16x or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk16x) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame format latched per word at pop time.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int MSB_FIRST  = 0
) (
    input  logic                          clk16x,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wr,
    input  logic                          par_en,
    input  logic                          par_odd,
    input  logic                          stop2,
    input  logic                          clr_ovf,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tsre,
    output logic                          overflow,
    output logic                          sdo
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_left;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] word_l;
    logic                 par_en_l;
    logic                 par_odd_l;
    logic                 stop2_l;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 pop;
    logic                 bit_end;
    logic                 parity;

    function automatic logic out_bit(input logic [DATA_BITS-1:0] s);
        return (MSB_FIRST != 0) ? s[DATA_BITS-1] : s[0];
    endfunction

    function automatic logic [DATA_BITS-1:0] shift_next(input logic [DATA_BITS-1:0] s);
        if (MSB_FIRST != 0)
            return {s[DATA_BITS-2:0], 1'b0};
        return {1'b0, s[DATA_BITS-1:1]};
    endfunction

    sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk16x (clk16x),
        .rst_n  (rst_n),
        .push   (wr),
        .pop    (pop),
        .din    (din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign bit_end = (cnt == '0);
    // Pop from idle, or on the last stop cycle so the next start bit follows with no gap.
    assign pop     = !fifo_empty &&
                     ((state == IDLE) || (state == STOP && bit_end && !stop_left));
    assign parity  = (^word_l) ^ (par_odd_l == PAR_ODD);

    always_ff @(posedge clk16x) begin
        if (pop) begin
            shifter   <= fifo_dout;
            word_l    <= fifo_dout;
            par_en_l  <= par_en;
            par_odd_l <= par_odd;
            stop2_l   <= stop2;
        end else if ((state == START || state == DATA) && bit_end) begin
            shifter <= shift_next(shifter);
        end
    end

    always_ff @(posedge clk16x or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_left <= 1'b0;
            sdo       <= 1'b1;
            tsre      <= 1'b1;
        end else begin
            cnt <= bit_end ? CNT_W'(OVERSAMPLE-1) : cnt - 1'b1;
            case (state)
                IDLE: begin
                    cnt <= CNT_W'(OVERSAMPLE-1);
                    if (pop) begin
                        state <= START;
                        sdo   <= 1'b0;
                        tsre  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        sdo     <= out_bit(shifter);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS-1)) begin
                            if (par_en_l) begin
                                state <= PARITY;
                                sdo   <= parity;
                            end else begin
                                state     <= STOP;
                                sdo       <= 1'b1;
                                stop_left <= stop2_l;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            sdo     <= out_bit(shifter);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state     <= STOP;
                        sdo       <= 1'b1;
                        stop_left <= stop2_l;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_left) begin
                            stop_left <= 1'b0;
                        end else if (pop) begin
                            state <= START;
                            sdo   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tsre  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sdo   <= 1'b1;
                    tsre  <= 1'b1;
                end
            endcase
        end
    end

    // A refused write takes priority over a clear in the same cycle.
    always_ff @(posedge clk16x or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (wr && fifo_full && !pop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame table plus burst, mode-change and reset sequences.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int OS    = 16;

    logic       clk16x  = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       wr      = 1'b0;
    logic       par_en  = 1'b0;
    logic       par_odd = 1'b0;
    logic       stop2   = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       tsre;
    logic       overflow;
    logic       sdo;

    uart_tx_fifo #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH),
        .OVERSAMPLE (OS),
        .MSB_FIRST  (0)
    ) dut (
        .clk16x     (clk16x),
        .rst_n      (rst_n),
        .din        (din),
        .wr         (wr),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .stop2      (stop2),
        .clr_ovf    (clr_ovf),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .tsre       (tsre),
        .overflow   (overflow),
        .sdo        (sdo)
    );

    always #5 clk16x = ~clk16x;

    int cyc = 0;
    always @(posedge clk16x) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk16x);
    endtask

    task automatic wait_tsre_low(input string name);
        int c = 0;
        while (tsre !== 1'b0 && c < 20) begin
            @(negedge clk16x);
            c++;
        end
        chk(name, tsre, 0);
    endtask

    // Frame bits in transmit order: bit 0 = start, then data, parity, stop(s).
    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        po;
        logic        s2;
        int          nbits;
        logic [11:0] frame;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        logic [11:0] got;
        int c;
        @(posedge clk16x); #1;
        din = v.d; par_en = v.pe; par_odd = v.po; stop2 = v.s2; wr = 1'b1;
        @(posedge clk16x); #1;
        wr = 1'b0;
        @(negedge clk16x);
        chk($sformatf("occupancy[%0d]", idx), {fifo_empty, fifo_count}, {1'b0, 5'd1});
        @(negedge clk16x);
        chk($sformatf("start_latency[%0d]", idx), {sdo, tsre, fifo_empty}, 3'b001);
        c = 0;
        got = '0;
        while (tsre === 1'b0 && c < 400) begin
            if ((c % OS) == OS/2 && (c / OS) < 12) got[c / OS] = sdo;
            c++;
            @(negedge clk16x);
        end
        chk($sformatf("frame_bits[%0d]", idx), got, v.frame);
        chk($sformatf("frame_len[%0d]", idx), c, v.nbits * OS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int t2;
        int bad;

        vecs[0] = '{d: 8'hA5, pe: 1'b0, po: 1'b0, s2: 1'b0, nbits: 10, frame: 12'h34A};
        vecs[1] = '{d: 8'h01, pe: 1'b1, po: 1'b0, s2: 1'b0, nbits: 11, frame: 12'h602};
        vecs[2] = '{d: 8'h01, pe: 1'b1, po: 1'b1, s2: 1'b0, nbits: 11, frame: 12'h402};
        vecs[3] = '{d: 8'h01, pe: 1'b1, po: 1'b0, s2: 1'b1, nbits: 12, frame: 12'hE02};
        vecs[4] = '{d: 8'hFF, pe: 1'b0, po: 1'b0, s2: 1'b1, nbits: 11, frame: 12'h7FE};
        vecs[5] = '{d: 8'h3C, pe: 1'b1, po: 1'b0, s2: 1'b0, nbits: 11, frame: 12'h478};
        vecs[6] = '{d: 8'h80, pe: 1'b1, po: 1'b1, s2: 1'b0, nbits: 11, frame: 12'h500};

        // Reset state
        repeat (3) @(negedge clk16x);
        chk("reset_sdo", sdo, 1);
        chk("reset_tsre", tsre, 1);
        chk("reset_empty", fifo_empty, 1);
        chk("reset_full", fifo_full, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk16x);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            repeat (3) @(negedge clk16x);
        end

        // Burst: one frame in flight, 16 queued, 17th dropped, then a write on the STOP-end pop
        par_en = 1'b0; par_odd = PAR_EVEN; stop2 = 1'b0;
        @(negedge clk16x);
        din = 8'h00; wr = 1'b1;
        @(negedge clk16x);
        wr = 1'b0;
        wait_tsre_low("burst_start");
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            din = 8'(8'h10 + i);
            wr  = 1'b1;
            @(negedge clk16x);
        end
        chk("burst_full", {fifo_full, fifo_count}, {1'b1, 5'd16});
        chk("burst_no_ovf_yet", overflow, 0);
        din = 8'hEE;
        @(negedge clk16x);
        wr = 1'b0;
        chk("burst_overflow", overflow, 1);
        chk("burst_count_held", fifo_count, 16);
        clr_ovf = 1'b1;
        @(negedge clk16x);
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        wait_cyc(t0 + 159);
        din = 8'h5A; wr = 1'b1;
        @(negedge clk16x);
        wr = 1'b0;
        chk("full_push_pop_count", fifo_count, 16);
        chk("full_push_pop_ovf", overflow, 0);
        chk("b2b_start", {sdo, tsre}, 2'b00);
        for (int f = 0; f < 17; f++) begin
            logic [9:0] got;
            logic [7:0] exp_d;
            for (int b = 0; b < 10; b++) begin
                wait_cyc(t0 + 160 * (f + 1) + 16 * b + 8);
                got[b] = sdo;
            end
            exp_d = (f < 16) ? 8'(8'h10 + f) : 8'h5A;
            chk($sformatf("burst_frame%0d", f), got, {1'b1, exp_d, 1'b0});
        end
        wait_cyc(t0 + 160 * 18 - 1);
        chk("burst_last_busy", tsre, 0);
        @(negedge clk16x);
        chk("burst_idle", {tsre, fifo_empty}, 2'b11);

        // Mode inputs changed mid-frame apply only to the next word
        repeat (3) @(negedge clk16x);
        din = 8'h01; par_en = 1'b0; par_odd = PAR_EVEN; stop2 = 1'b0; wr = 1'b1;
        @(negedge clk16x);
        wr = 1'b0;
        wait_tsre_low("toggle_start");
        t1 = cyc;
        par_en = 1'b1; stop2 = 1'b1; din = 8'h01; wr = 1'b1;
        @(negedge clk16x);
        wr = 1'b0;
        begin
            logic [9:0]  ga;
            logic [11:0] gb;
            for (int b = 0; b < 10; b++) begin
                wait_cyc(t1 + 16 * b + 8);
                ga[b] = sdo;
            end
            chk("toggle_frame_a", ga, 10'h202);
            for (int b = 0; b < 12; b++) begin
                wait_cyc(t1 + 160 + 16 * b + 8);
                gb[b] = sdo;
            end
            chk("toggle_frame_b", gb, 12'hE02);
        end
        wait_cyc(t1 + 160 + frame_cycles(DB, 1, 1, OS) - 1);
        chk("toggle_b_busy", tsre, 0);
        @(negedge clk16x);
        chk("toggle_b_done", tsre, 1);
        par_en = 1'b0; stop2 = 1'b0;

        // Reset during DATA with three words queued
        repeat (3) @(negedge clk16x);
        for (int i = 0; i < 4; i++) begin
            din = 8'(8'h11 * i);
            wr  = 1'b1;
            @(negedge clk16x);
        end
        wr = 1'b0;
        wait_tsre_low("rst_frame_start");
        t2 = cyc;
        wait_cyc(t2 + 16 * 3 + 4);
        chk("pre_reset_state", {sdo, fifo_count}, {1'b0, 5'd3});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_sdo", {sdo, tsre}, 2'b11);
        chk("async_reset_fifo", {fifo_empty, fifo_count}, {1'b1, 5'd0});
        repeat (2) @(negedge clk16x);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk16x);
            if (sdo !== 1'b1 || tsre !== 1'b1 || fifo_empty !== 1'b1) bad++;
        end
        chk("no_frame_after_reset", bad, 0);
        run_vec(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
